adsb_frame_ctrl: RTL and testbench
==================================

Name: adsb_frame_ctrl

Overview:
Controller and frame assembler downstream of the ADS-B receiver chain (pulse detector, PPM demod, watchdog). It sequences the detector through det_ena and collects the demodulated bit stream into 56- or 112-bit frames, choosing the length from the DF field. It qualifies each frame on bit confidence and buffers accepted frames in a small FIFO for a valid/ready host interface. Detection is held off whenever the FIFO is full.

Parameters:
MAXBITS, 112, long frame length; short frame is MAXBITS/2.
DEPTH, 2, FIFO entries; power of 2, at least 2.
CONF_W, 7, width of the low-confidence bit counter; saturates at 2^CONF_W-1.
CNT_W, 16, width of the frame and drop statistics counters.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ena  in  1  sample-rate enable; qualifies all rx_* inputs except rx_watchdog_reset
run  in  1  software run enable
max_lowconf  in  CONF_W  maximum low-confidence bits accepted per frame
rx_data_start  in  1  preamble found pulse
rx_ena_out  in  1  bit strobe
rx_data  in  1  demodulated bit
rx_conf  in  1  bit confidence (1 = good)
rx_done  in  1  demod frame-done pulse
rx_watchdog_reset  in  1  receiver abort; sampled every clock
det_ena  out  1  detect enable to the pulse detector
busy  out  1  high in COLLECT or COMMIT
frm_valid  out  1  FIFO not empty
frm_ready  in  1  host accepts the head entry
frm_data  out  MAXBITS  head frame, MSB = first bit received
frm_long  out  1  head frame is 112 bits
frm_lowconf  out  CONF_W  low-confidence bit count of head frame
frm_count  out  CNT_W  accepted frames, wraps
drop_count  out  CNT_W  discarded frames, wraps

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty. det_ena=0, busy=0, frm_valid=0, frm_data/frm_long/frm_lowconf=0, both counters 0.
- IDLE: det_ena=0. If run=1 and the FIFO is not full, go to ARM next clock.
- ARM: det_ena=1.
  - ena and rx_data_start: go to COLLECT. Clear the shift register, bitcnt and lowconf.
  - Otherwise, if run=0: go to IDLE.
- COLLECT: det_ena=1.
  - On each ena and rx_ena_out: shift rx_data in MSB-first, increment bitcnt, and increment lowconf (saturating) when rx_conf=0.
  - Length is latched when bitcnt reaches 5: long = first bit received (DF >= 16).
  - When bitcnt reaches 112 (long) or 56 (short), go to COMMIT.
  - run=0 does not abort a frame in progress.
- COMMIT (1 clock), evaluated in this order:
  - If lowconf > max_lowconf: discard the frame and increment drop_count.
  - Otherwise push to the FIFO and increment frm_count. A short frame is stored in frm_data[111:56] with [55:0]=0. The frm_long and lowconf values are stored with it.
  - Next state is ARM if run=1 and the FIFO is not full after this clock's push and pop. Otherwise it is IDLE.
- Abort, in ARM, COLLECT or COMMIT:
  - rx_watchdog_reset=1, or ena and rx_done while in COLLECT before the length is reached: discard the frame.
  - Increment drop_count only if the abort occurs in COLLECT.
  - Next state is IDLE.
  - rx_watchdog_reset has priority over every other event in the same clock.
- The FIFO is never full in COMMIT, because ARM is entered only when it is not full and nothing is pushed during COLLECT. This holds as an assertion.
- FIFO:
  - Show-ahead: frm_data, frm_long and frm_lowconf present the head entry whenever frm_valid=1.
  - Pop on frm_valid and frm_ready. frm_ready is ignored when the FIFO is empty.
  - Push and pop in the same clock are legal at any occupancy.
  - Outputs are registered; the head updates the clock after a pop.
- Latency:
  - Last bit strobe to frm_valid=1 (empty FIFO): 2 clocks (COMMIT, then the registered head).
  - FIFO full to det_ena=0: det_ena drops on the clock leaving COMMIT.
  - Pop from full FIFO to det_ena=1: 2 clocks (IDLE, then ARM).
- rx_data_start in COLLECT is ignored; rx_ena_out in ARM is ignored.
- Counters wrap modulo 2^CNT_W.

Test Plan:
1. run=1, max_lowconf=0. Send a 112-bit frame with DF=17 (0x8D4840D6202CC371C32CE0576098), all conf=1 -> frm_valid 2 clocks after the last bit, frm_data=that value, frm_long=1, frm_lowconf=0, frm_count=1.
2. 56-bit frame with DF=11 (0x5D4840D6 followed by 0x2C0C2A) -> frm_long=0, frm_data[111:56]=0x5D4840D62C0C2A, frm_data[55:0]=0, frm_count increments.
3. Pulse rx_watchdog_reset after bit 40 of a long frame -> no push, drop_count=1, det_ena low for 1 clock (IDLE), then re-arms.
4. DEPTH=2, frm_ready=0, send 2 frames -> det_ena=0 after the second COMMIT and a third preamble is ignored. Pulse frm_ready for one clock -> det_ena=1 exactly 2 clocks later, frm_data shows frame 2.
5. Frame with 10 conf=0 bits: max_lowconf=8 -> dropped, drop_count+1. Same frame with max_lowconf=10 -> accepted, frm_lowconf=10.
6. Drop run at bit 30 -> the frame completes and is pushed, state goes to IDLE, det_ena=0. Assert reset=0 mid-frame -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/adsb_frame_if.sv
// Host-side frame interface of adsb_frame_ctrl.
// master: the frame controller (drives the head entry of its FIFO).
// slave : the host (drives frm_ready).
//   frm_valid   - FIFO holds at least one frame
//   frm_ready   - host accepts the head entry this clock
//   frm_data    - head frame, MSB = first bit received
//   frm_long    - head frame is a long (MAXBITS) frame
//   frm_lowconf - low-confidence bit count of the head frame
interface adsb_frame_if #(
  parameter int MAXBITS = 112,
  parameter int CONF_W  = 7
) ();
  logic               frm_valid;
  logic               frm_ready;
  logic [MAXBITS-1:0] frm_data;
  logic               frm_long;
  logic [CONF_W-1:0]  frm_lowconf;

  modport master (
    output frm_valid, frm_data, frm_long, frm_lowconf,
    input  frm_ready
  );

  modport slave (
    input  frm_valid, frm_data, frm_long, frm_lowconf,
    output frm_ready
  );
endinterface

// File: rtl/adsb_frame_ctrl.sv
// ADS-B frame controller and assembler.
// Sequences the pulse detector via det_ena, shifts demodulated bits into a
// frame register, picks 56/112-bit length from the first DF bit, qualifies the
// frame on its low-confidence bit count and queues accepted frames in a
// show-ahead FIFO for the host.
// Ports:
//   clock, reset       - system clock, asynchronous active-low reset
//   ena                - sample-rate enable for rx_* (except rx_watchdog_reset)
//   run                - software run enable
//   max_lowconf        - low-confidence bits tolerated per frame
//   rx_data_start      - preamble found pulse
//   rx_ena_out         - bit strobe
//   rx_data, rx_conf   - demodulated bit and its confidence (1 = good)
//   rx_done            - demod frame-done pulse
//   rx_watchdog_reset  - receiver abort, sampled every clock
//   det_ena            - detector enable (ARM / COLLECT)
//   busy               - COLLECT or COMMIT
//   frm_count          - accepted frames (wraps)
//   drop_count         - discarded frames (wraps)
//   frm                - host frame interface (master side)
module adsb_frame_ctrl #(
  parameter int MAXBITS = 112,
  parameter int DEPTH   = 2,
  parameter int CONF_W  = 7,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              run,
  input  logic [CONF_W-1:0] max_lowconf,
  input  logic              rx_data_start,
  input  logic              rx_ena_out,
  input  logic              rx_data,
  input  logic              rx_conf,
  input  logic              rx_done,
  input  logic              rx_watchdog_reset,
  output logic              det_ena,
  output logic              busy,
  output logic [CNT_W-1:0]  frm_count,
  output logic [CNT_W-1:0]  drop_count,
  adsb_frame_if.master      frm
);

  localparam int SHORT = MAXBITS / 2;
  localparam int BC_W  = $clog2(MAXBITS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [BC_W-1:0]  LEN_L = BC_W'(MAXBITS);
  localparam logic [BC_W-1:0]  LEN_S = BC_W'(SHORT);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COLLECT, S_COMMIT} state_t;

  state_t             state, state_nxt;
  logic [MAXBITS-1:0] shreg;
  logic [BC_W-1:0]    bitcnt, bitcnt_inc;
  logic [CONF_W-1:0]  lowconf;
  logic               is_long;
  logic               frame_clr, push, pop, drop_inc;
  logic               strobe, start, done_abort, bit_last;
  logic               commit_ok, full, full_after_commit;
  logic [OCC_W-1:0]   occ, occ_after_commit;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [MAXBITS-1:0] push_data;
  logic [MAXBITS-1:0] mem_data [DEPTH];
  logic               mem_long [DEPTH];
  logic [CONF_W-1:0]  mem_low  [DEPTH];

  assign strobe     = ena & rx_ena_out;
  assign start      = ena & rx_data_start;
  assign done_abort = ena & rx_done;
  assign bitcnt_inc = bitcnt + BC_W'(1);
  // is_long is cleared at frame start and latched at bit 5, so the short
  // target is in force until the DF bit is known; 56 > 5 keeps this safe.
  assign bit_last   = strobe && (bitcnt_inc == (is_long ? LEN_L : LEN_S));

  assign full      = (occ == OCC_FULL);
  assign pop       = frm.frm_valid & frm.frm_ready;
  assign commit_ok = (lowconf <= max_lowconf);
  // Occupancy after a COMMIT clock, computed without going through push so
  // the next-state logic has no combinational loop.
  assign occ_after_commit  = occ + OCC_W'(commit_ok) - OCC_W'(pop);
  assign full_after_commit = (occ_after_commit == OCC_FULL);

  assign push_data = is_long ? shreg : {shreg[SHORT-1:0], {(MAXBITS-SHORT){1'b0}}};

  assign det_ena = (state == S_ARM) || (state == S_COLLECT);
  assign busy    = (state == S_COLLECT) || (state == S_COMMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_clr = 1'b0;
    push      = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && !full) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (rx_watchdog_reset) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_COLLECT;
          frame_clr = 1'b1;
        end else if (!run) begin
          state_nxt = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (rx_watchdog_reset) begin
          state_nxt = S_IDLE;
          drop_inc  = 1'b1;
        end else if (bit_last) begin
          state_nxt = S_COMMIT;
        end else if (done_abort) begin
          state_nxt = S_IDLE;
          drop_inc  = 1'b1;
        end
      end
      S_COMMIT: begin
        if (rx_watchdog_reset) begin
          state_nxt = S_IDLE;
        end else begin
          push      = commit_ok;
          drop_inc  = !commit_ok;
          state_nxt = (run && !full_after_commit) ? S_ARM : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame assembly: counters and length latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitcnt  <= '0;
      lowconf <= '0;
      is_long <= 1'b0;
    end else if (frame_clr) begin
      bitcnt  <= '0;
      lowconf <= '0;
      is_long <= 1'b0;
    end else if (state == S_COLLECT && strobe) begin
      bitcnt <= bitcnt_inc;
      if (!rx_conf && lowconf != '1) lowconf <= lowconf + CONF_W'(1);
      // After four shifts the first bit sits in shreg[3]; it is the DF MSB.
      if (bitcnt == BC_W'(4)) is_long <= shreg[3];
    end
  end

  always_ff @(posedge clock) begin
    if (frame_clr)                             shreg <= '0;
    else if (state == S_COLLECT && strobe)     shreg <= {shreg[MAXBITS-2:0], rx_data};
  end

  // Statistics
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frm_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push)     frm_count  <= frm_count + CNT_W'(1);
      if (drop_inc) drop_count <= drop_count + CNT_W'(1);
    end
  end

  // Frame FIFO: show-ahead, head read straight from storage registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_long[i] <= 1'b0;
        mem_low[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_long[wr_ptr] <= is_long;
        mem_low[wr_ptr]  <= lowconf;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign frm.frm_valid   = (occ != '0);
  assign frm.frm_data    = mem_data[rd_ptr];
  assign frm.frm_long    = mem_long[rd_ptr];
  assign frm.frm_lowconf = mem_low[rd_ptr];

  // ARM is only entered with room in the FIFO and COLLECT never pushes.
  a_commit_not_full: assert property (@(posedge clock) disable iff (!reset)
    (state == S_COMMIT) |-> !full);

endmodule

// File: tb/tb_adsb_frame_ctrl.sv
// Directed bench for adsb_frame_ctrl with a frame scoreboard.
module tb_adsb_frame_ctrl;

  localparam int MAXBITS = 112;
  localparam int DEPTH   = 2;
  localparam int CONF_W  = 7;
  localparam int CNT_W   = 16;

  localparam logic [111:0] F1 = 112'h8D4840D6202CC371C32CE0576098;
  localparam logic [111:0] F2 = {56'h5D4840D62C0C2A, 56'h0};

  typedef struct {
    logic [111:0] data;
    logic         lng;
    logic [6:0]   low;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              ena, run, rx_data_start, rx_ena_out, rx_data, rx_conf;
  logic              rx_done, rx_watchdog_reset;
  logic [CONF_W-1:0] max_lowconf;
  logic              det_ena, busy;
  logic [CNT_W-1:0]  frm_count, drop_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  adsb_frame_if #(.MAXBITS(MAXBITS), .CONF_W(CONF_W)) frm_if ();

  adsb_frame_ctrl #(
    .MAXBITS(MAXBITS), .DEPTH(DEPTH), .CONF_W(CONF_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .ena(ena), .run(run),
    .max_lowconf(max_lowconf), .rx_data_start(rx_data_start),
    .rx_ena_out(rx_ena_out), .rx_data(rx_data), .rx_conf(rx_conf),
    .rx_done(rx_done), .rx_watchdog_reset(rx_watchdog_reset),
    .det_ena(det_ena), .busy(busy), .frm_count(frm_count),
    .drop_count(drop_count), .frm(frm_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse();
    rx_data_start = 1'b1;
    tick();
    rx_data_start = 1'b0;
  endtask

  // Bits first..last-1 of v (v[111] is bit 0); bits below nlow carry conf=0.
  task automatic send_bits(input logic [111:0] v, input int first, input int last, input int nlow);
    for (int i = first; i < last; i++) begin
      rx_ena_out = 1'b1;
      rx_data    = v[111-i];
      rx_conf    = (i >= nlow);
      tick();
    end
    rx_ena_out = 1'b0;
    rx_data    = 1'b0;
    rx_conf    = 1'b1;
  endtask

  task automatic expect_frame(input logic [111:0] d, input logic l, input logic [6:0] lc);
    exp_t e;
    e.data = d;
    e.lng  = l;
    e.low  = lc;
    sb.push_back(e);
  endtask

  // Scoreboard: compare the head entry whenever the host pops it.
  always @(negedge clock) begin
    if (reset && frm_if.frm_valid && frm_if.frm_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", 128'(frm_if.frm_data), 128'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 128'(frm_if.frm_data), 128'(e.data));
        check("sb_long", 128'(frm_if.frm_long), 128'(e.lng));
        check("sb_lowconf", 128'(frm_if.frm_lowconf), 128'(e.low));
      end
    end
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_det_ena"}, 128'(det_ena), 128'(0));
    check({pfx, "_busy"}, 128'(busy), 128'(0));
    check({pfx, "_valid"}, 128'(frm_if.frm_valid), 128'(0));
    check({pfx, "_data"}, 128'(frm_if.frm_data), 128'(0));
    check({pfx, "_long"}, 128'(frm_if.frm_long), 128'(0));
    check({pfx, "_lowconf"}, 128'(frm_if.frm_lowconf), 128'(0));
    check({pfx, "_frm_count"}, 128'(frm_count), 128'(0));
    check({pfx, "_drop_count"}, 128'(drop_count), 128'(0));
  endtask

  initial begin
    reset = 1'b0; ena = 1'b1; run = 1'b0; max_lowconf = '0;
    rx_data_start = 1'b0; rx_ena_out = 1'b0; rx_data = 1'b0; rx_conf = 1'b1;
    rx_done = 1'b0; rx_watchdog_reset = 1'b0; frm_if.frm_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b1;
    tick();
    check("idle_det_ena", 128'(det_ena), 128'(0));

    // 1: long frame DF=17
    run = 1'b1;
    tick();
    check("arm_det_ena", 128'(det_ena), 128'(1));
    expect_frame(F1, 1'b1, 7'd0);
    start_pulse();
    check("collect_busy", 128'(busy), 128'(1));
    send_bits(F1, 0, 112, 0);
    check("t1_valid_lat1", 128'(frm_if.frm_valid), 128'(0));
    tick();
    check("t1_valid_lat2", 128'(frm_if.frm_valid), 128'(1));
    check("t1_frm_count", 128'(frm_count), 128'(1));
    check("t1_rearm", 128'(det_ena), 128'(1));
    tick();
    check("t1_popped", 128'(frm_if.frm_valid), 128'(0));

    // 2: short frame DF=11, with a strobe while ena=0 that must be ignored
    expect_frame(F2, 1'b0, 7'd0);
    start_pulse();
    send_bits(F2, 0, 20, 0);
    ena = 1'b0; rx_ena_out = 1'b1; rx_data = ~F2[91];
    tick();
    ena = 1'b1; rx_ena_out = 1'b0;
    send_bits(F2, 20, 56, 0);
    tick();
    check("t2_valid", 128'(frm_if.frm_valid), 128'(1));
    check("t2_frm_count", 128'(frm_count), 128'(2));
    tick();

    // 3: watchdog after bit 40, then rx_done abort after bit 30
    start_pulse();
    send_bits(F1, 0, 40, 0);
    rx_watchdog_reset = 1'b1;
    tick();
    rx_watchdog_reset = 1'b0;
    check("t3_wd_det_ena", 128'(det_ena), 128'(0));
    check("t3_wd_busy", 128'(busy), 128'(0));
    check("t3_wd_drop", 128'(drop_count), 128'(1));
    tick();
    check("t3_wd_rearm", 128'(det_ena), 128'(1));
    check("t3_wd_nopush", 128'(frm_count), 128'(2));
    start_pulse();
    send_bits(F1, 0, 30, 0);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    check("t3_done_drop", 128'(drop_count), 128'(2));
    check("t3_done_det_ena", 128'(det_ena), 128'(0));
    tick();
    check("t3_done_rearm", 128'(det_ena), 128'(1));

    // 4: fill the FIFO with the host stalled
    frm_if.frm_ready = 1'b0;
    expect_frame(F1, 1'b1, 7'd0);
    start_pulse();
    send_bits(F1, 0, 112, 0);
    tick();
    expect_frame(F2, 1'b0, 7'd0);
    start_pulse();
    send_bits(F2, 0, 56, 0);
    tick();
    check("t4_full_det_ena", 128'(det_ena), 128'(0));
    check("t4_full_valid", 128'(frm_if.frm_valid), 128'(1));
    check("t4_frm_count", 128'(frm_count), 128'(4));
    rx_data_start = 1'b1;
    tick();
    rx_data_start = 1'b0;
    tick();
    check("t4_ignored_busy", 128'(busy), 128'(0));
    check("t4_ignored_det_ena", 128'(det_ena), 128'(0));
    frm_if.frm_ready = 1'b1;
    tick();
    frm_if.frm_ready = 1'b0;
    check("t4_pop_lat1", 128'(det_ena), 128'(0));
    tick();
    check("t4_pop_lat2", 128'(det_ena), 128'(1));
    check("t4_head_data", 128'(frm_if.frm_data), 128'(F2));
    check("t4_head_long", 128'(frm_if.frm_long), 128'(0));
    frm_if.frm_ready = 1'b1;
    tick();

    // 5: confidence qualification with 10 low-confidence bits
    max_lowconf = 7'd8;
    start_pulse();
    send_bits(F1, 0, 112, 10);
    tick();
    check("t5_drop", 128'(drop_count), 128'(3));
    check("t5_drop_nopush", 128'(frm_count), 128'(4));
    check("t5_drop_valid", 128'(frm_if.frm_valid), 128'(0));
    max_lowconf = 7'd10;
    expect_frame(F1, 1'b1, 7'd10);
    start_pulse();
    send_bits(F1, 0, 50, 10);
    rx_data_start = 1'b1;
    tick();
    rx_data_start = 1'b0;
    send_bits(F1, 50, 112, 10);
    tick();
    check("t5_accept_count", 128'(frm_count), 128'(5));
    check("t5_accept_lowconf", 128'(frm_if.frm_lowconf), 128'(10));
    check("t5_accept_valid", 128'(frm_if.frm_valid), 128'(1));
    tick();

    // 6: run dropped mid-frame, then asynchronous reset mid-frame
    frm_if.frm_ready = 1'b0;
    max_lowconf = 7'd0;
    expect_frame(F1, 1'b1, 7'd0);
    start_pulse();
    send_bits(F1, 0, 30, 0);
    run = 1'b0;
    send_bits(F1, 30, 112, 0);
    check("t6_commit_busy", 128'(busy), 128'(1));
    tick();
    check("t6_idle_det_ena", 128'(det_ena), 128'(0));
    check("t6_valid", 128'(frm_if.frm_valid), 128'(1));
    check("t6_frm_count", 128'(frm_count), 128'(6));
    tick();
    check("t6_stay_idle", 128'(det_ena), 128'(0));
    run = 1'b1;
    tick();
    start_pulse();
    send_bits(F1, 0, 20, 0);
    check("t6_mid_busy", 128'(busy), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
